// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART memory loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_AHI,
    S_ALO,
    S_LHI,
    S_LLO,
    S_DATA,
    S_SUM
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_phase_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SUM     = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchronizer, baud counter and LSB-first shifter.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned DIV = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       ferr
);

  localparam int unsigned CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);

  logic            sync1;
  logic            sync2;
  logic            prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  rx_phase_t       phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      prev       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      phase      <= RX_IDLE;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      prev       <= sync2;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      unique case (phase)
        RX_IDLE: begin
          if (prev && !sync2) begin
            phase <= RX_START;
            cnt   <= CW'(1);
          end
        end
        RX_START: begin
          // A line already back high at mid-start is a glitch: drop silently.
          if (cnt == HALF_C) begin
            if (sync2) begin
              phase <= RX_IDLE;
            end else begin
              phase   <= RX_BITS;
              cnt     <= CW'(1);
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BITS: begin
          if (cnt == DIV_C) begin
            shift <= {sync2, shift[7:1]};
            cnt   <= CW'(1);
            if (bit_idx == 3'd7) begin
              phase <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == DIV_C) begin
            phase <= RX_IDLE;
            if (sync2) begin
              data_byte  <= shift;
              byte_valid <= 1'b1;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: phase <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Packet framing FSM: A5, address, length, data, checksum -> memory writes.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned BAUD    = 230400,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 2500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              we,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  logic [7:0]    data_byte;
  logic          byte_valid;
  logic          ferr;

  state_t        state;
  logic [15:0]   addr;
  logic [15:0]   len;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_byte  (data_byte),
    .byte_valid (byte_valid),
    .ferr       (ferr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_SYNC;
      addr     <= '0;
      len      <= '0;
      sum      <= '0;
      tcnt     <= '0;
      we       <= 1'b0;
      a        <= '0;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;

      if (state == S_SYNC || byte_valid) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      // busy is kept in step with state so it is a registered copy of state != SYNC.
      if (state != S_SYNC && ferr) begin
        err      <= 1'b1;
        err_code <= ERR_FRAME;
        state    <= S_SYNC;
        busy     <= 1'b0;
      end else if (state != S_SYNC && !byte_valid && tcnt == TLIM) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= S_SYNC;
        busy     <= 1'b0;
      end else if (byte_valid) begin
        unique case (state)
          S_SYNC: begin
            if (data_byte == SYNC_BYTE) begin
              state <= S_AHI;
              busy  <= 1'b1;
              sum   <= '0;
            end
          end
          S_AHI: begin
            addr[15:8] <= data_byte;
            state      <= S_ALO;
          end
          S_ALO: begin
            addr[7:0] <= data_byte;
            state     <= S_LHI;
          end
          S_LHI: begin
            len[15:8] <= data_byte;
            state     <= S_LLO;
          end
          S_LLO: begin
            len[7:0] <= data_byte;
            state    <= ({len[15:8], data_byte} != 16'd0) ? S_DATA : S_SUM;
          end
          S_DATA: begin
            we    <= 1'b1;
            a     <= addr[ADDR_W-1:0];
            d     <= data_byte;
            addr  <= addr + 16'd1;
            sum   <= sum + data_byte;
            len   <= len - 16'd1;
            if (len == 16'd1) begin
              state <= S_SUM;
            end
          end
          S_SUM: begin
            if (data_byte == sum) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_SUM;
            end
            state <= S_SYNC;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_SYNC;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
